// File: rtl/golden_nonce_reporter_if.sv
// Byte-wide transmit channel from the nonce reporter to the UART path.
// A byte moves on every rising clock where tx_valid && tx_ready; once tx_valid is up, tx_data and tx_valid hold until that handshake.
interface golden_nonce_reporter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/golden_nonce_reporter.sv
// Buffers golden-ticket nonces in a small FIFO and serialises each one as a
// framed byte stream (optional header, then nonce MSB first) on a valid/ready link.
module golden_nonce_reporter #(
  parameter int          DEPTH_LOG2  = 2,
  parameter logic [7:0]  HEADER_BYTE = 8'h4E,
  parameter bit          SEND_HEADER = 1'b1
) (
  input  logic                    hash_clk,
  input  logic                    reset_n,
  input  logic                    new_golden_ticket,
  input  logic [31:0]             golden_nonce,
  input  logic                    flush,
  golden_nonce_reporter_if.master tx,
  output logic [DEPTH_LOG2:0]     fifo_count,
  output logic                    overflow,
  output logic [2:0]              dbg_state
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_B3   = 3'd2,
    S_B2   = 3'd3,
    S_B1   = 3'd4,
    S_B0   = 3'd5
  } state_t;

  localparam state_t S_FIRST = SEND_HEADER ? S_HDR : S_B3;

  logic [31:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ticket_q;
  logic                  r_overflow;
  logic [31:0]           r_nonce;
  state_t                r_state;
  logic [7:0]            r_tx_data;
  logic                  r_tx_valid;

  state_t                w_state_nxt;
  logic [31:0]           w_nonce_nxt;
  logic [7:0]            w_tx_data_nxt;
  logic                  w_tx_valid_nxt;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_push_req;
  logic                  w_hs;
  logic                  w_empty;
  logic                  w_full;

  assign w_hs       = r_tx_valid & tx.tx_ready;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_CNT);
  // A ticket arriving with flush belongs to the old work and is discarded.
  assign w_push_req = new_golden_ticket & ~r_ticket_q & ~flush;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  // State register
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_nonce <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_nonce <= w_nonce_nxt;
    end
  end

  // Next state; a pop is only taken when the serialiser is free to load.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !flush) begin
          w_pop       = 1'b1;
          w_state_nxt = S_FIRST;
        end
      end
      S_HDR:  if (w_hs) w_state_nxt = S_B3;
      S_B3:   if (w_hs) w_state_nxt = S_B2;
      S_B2:   if (w_hs) w_state_nxt = S_B1;
      S_B1:   if (w_hs) w_state_nxt = S_B0;
      S_B0: begin
        if (w_hs) begin
          if (!w_empty && !flush) begin
            w_pop       = 1'b1;
            w_state_nxt = S_FIRST;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_nonce_nxt = w_pop ? r_mem[r_rd_ptr] : r_nonce;

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_tx_data_nxt  = 8'h00;
    w_tx_valid_nxt = 1'b1;
    case (w_state_nxt)
      S_HDR:   w_tx_data_nxt = HEADER_BYTE;
      S_B3:    w_tx_data_nxt = w_nonce_nxt[31:24];
      S_B2:    w_tx_data_nxt = w_nonce_nxt[23:16];
      S_B1:    w_tx_data_nxt = w_nonce_nxt[15:8];
      S_B0:    w_tx_data_nxt = w_nonce_nxt[7:0];
      default: w_tx_valid_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else begin
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
    end
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ticket_q <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_ticket_q <= new_golden_ticket;
      if (flush) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        if (w_drop) r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge hash_clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= golden_nonce;
  end

  assign tx.tx_data  = r_tx_data;
  assign tx.tx_valid = r_tx_valid;
  assign fifo_count  = r_count;
  assign overflow    = r_overflow;
  assign dbg_state   = r_state;

endmodule

// File: doc/golden_nonce_reporter.md
Name:
golden_nonce_reporter

Overview:
- Sits directly downstream of the miner core and upstream of the UART transmit path.
- Captures each golden-ticket event and buffers the 32-bit winning nonce in a small FIFO.
- Serialises each buffered nonce into a framed byte stream, driving a byte-wide valid/ready transmit interface.
- Prevents nonces from being lost while the slow UART is still busy with a previous frame.

Parameters:
- DEPTH_LOG2, 2, log2 of FIFO depth (default 4 entries); legal range 1..4.
- HEADER_BYTE, 8'h4E, frame start byte sent before each nonce.
- SEND_HEADER, 1, 1 = emit HEADER_BYTE before each nonce; 0 = emit nonce bytes only.

Ports:
- hash_clk  in  1  sole clock; every register is clocked on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- new_golden_ticket  in  1  high while the miner reports a hit (level, may stay high several cycles).
- golden_nonce  in  32  winning nonce, valid whenever new_golden_ticket is high.
- flush  in  1  one-cycle pulse on new work; discards buffered stale nonces.
- tx_data  out  8  byte presented to the transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts tx_data this cycle.
- fifo_count  out  DEPTH_LOG2+1  number of occupied FIFO entries.
- overflow  out  1  sticky flag: at least one nonce was dropped because the FIFO was full.

Behaviour:
Reset:
- Reset is asynchronous, active-low, on reset_n.
- While reset_n=0: tx_data=0, tx_valid=0, fifo_count=0, overflow=0, FSM=IDLE, ticket edge register=0, FIFO pointers=0.

Capture:
- Push occurs on the rising edge of new_golden_ticket: the registered previous value is 0 and the current value is 1.
- Exactly one entry is pushed per edge, regardless of how long the level stays high.
- golden_nonce is sampled in the edge cycle.
- fifo_count reflects the push on the next clock.

FIFO:
- Circular buffer with wrapping read and write pointers of DEPTH_LOG2 bits.
- Full when fifo_count = 2^DEPTH_LOG2; the push is then dropped and overflow is set.
- Same-cycle push and pop with FIFO full: the pop frees a slot, the push is accepted, and overflow is not set.
- Same-cycle push and pop with FIFO empty: the push lands and no pop occurs; the FSM pops it on a later cycle.

Flush:
- Pointers and fifo_count are cleared next cycle; overflow is cleared.
- A push in the same cycle as flush is discarded (the nonce is stale).
- A frame already loaded into the serialiser completes untouched.

Serialiser FSM (states IDLE, HDR, B3, B2, B1, B0):
- IDLE: if fifo_count>0, pop the head into a 32-bit shift register and go to HDR (SEND_HEADER=1) or B3 (SEND_HEADER=0). tx_valid=0.
- HDR: tx_data=HEADER_BYTE.
- B3..B0: tx_data = nonce[31:24], [23:16], [15:8], [7:0] respectively (MSB first).
- Each non-IDLE state holds tx_valid=1.
- Advance only on a cycle with tx_valid & tx_ready.
- tx_data and tx_valid stay stable while tx_ready=0.
- After the B0 handshake: if fifo_count>0, pop and jump to HDR/B3 (back-to-back, no idle bubble); else go to IDLE.
- Latency: the first byte is valid 2 cycles after the ticket edge (push cycle +1 pop, +1 registered output).
- Frame length: 5 bytes (SEND_HEADER=1) or 4 bytes (SEND_HEADER=0).
- tx_ready is ignored while tx_valid=0.

Reset mid-frame:
- Everything returns to reset values immediately; the partial frame is abandoned and no further bytes are sent.

Test Plan:
- Single hit: new_golden_ticket pulsed 1 cycle with nonce 32'hDEADBEEF, tx_ready=1 -> bytes 4E DE AD BE EF on 5 consecutive cycles, then tx_valid=0; fifo_count returns to 0.
- Held level: new_golden_ticket held high 20 cycles with nonce 32'h00000010 -> exactly one 5-byte frame; fifo_count never exceeds 1.
- Backpressure and overflow: tx_ready=0, six ticket edges with nonces 1..6 -> fifo_count stalls at 4 after the first pop (first nonce sits in the serialiser); overflow=1. After releasing tx_ready, frames carry nonces 1..5 in order, nonce 6 is lost, and frames are back-to-back with no gap.
- Stall stability: tx_ready toggles 1,0,0,1 during a frame -> tx_data is unchanged during the 0 cycles and no byte is duplicated or skipped.
- Flush: queue 3 nonces, stall on the B2 byte, pulse flush together with a new ticket edge -> current frame finishes, no further frames follow, fifo_count=0, overflow=0.
- Async reset mid-frame: assert reset_n=0 between clock edges during B1 -> tx_valid drops immediately without waiting for a clock; after release, no residual bytes; a new hit 32'h12345678 produces a clean 4E 12 34 56 78 frame.
